// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with an integrated LIFO return-address stack
// and interrupt vectoring; every output except PC_PLUS1 is registered.
module pc_stack_unit #(
    parameter int unsigned      WIDTH       = 10,
    parameter int unsigned      STACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] INTR_VECTOR = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             PC_LD,
    input  logic             PC_INC,
    input  logic             PC_CALL,
    input  logic             PC_RET,
    input  logic             PC_INTR,
    output logic [WIDTH-1:0] PC_COUNT,
    output logic [WIDTH-1:0] PC_PLUS1,
    output logic             STACK_FULL,
    output logic             STACK_EMPTY,
    output logic             STACK_ERR
);

    localparam int unsigned      CW      = $clog2(STACK_DEPTH + 1);
    localparam int unsigned      AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(STACK_DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_LD   = 3'd2,
        CMD_RET  = 3'd3,
        CMD_CALL = 3'd4,
        CMD_INTR = 3'd5
    } cmd_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    cmd_e             cmd_s;
    logic             push_en_s;
    logic [WIDTH-1:0] push_val_s;
    logic [WIDTH-1:0] top_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;
    logic [WIDTH-1:0] pc_plus1_s;

    assign pc_plus1_s = pc_q + PC_ONE;
    // Slot count_q is the next free entry; the top lives one below it.
    assign wr_idx_s   = count_q[AW-1:0];
    assign rd_idx_s   = AW'(count_q - ONE_C);
    assign top_s      = stack_q[rd_idx_s];

    // Fixed-priority command decode; lower-priority requests are dropped.
    always_comb begin
        cmd_s = CMD_HOLD;
        if (PC_INTR) begin
            cmd_s = CMD_INTR;
        end else if (PC_CALL) begin
            cmd_s = CMD_CALL;
        end else if (PC_RET) begin
            cmd_s = CMD_RET;
        end else if (PC_LD) begin
            cmd_s = CMD_LD;
        end else if (PC_INC) begin
            cmd_s = CMD_INC;
        end else begin
            cmd_s = CMD_HOLD;
        end
    end

    // Next-state for PC, stack pointer and flags.
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        err_d      = err_q;
        push_en_s  = 1'b0;
        push_val_s = {WIDTH{1'b0}};
        case (cmd_s)
            CMD_INTR, CMD_CALL: begin
                pc_d = (cmd_s == CMD_INTR) ? INTR_VECTOR : DIN;
                // A push onto a full stack is discarded but the jump still happens.
                if (count_q == DEPTH_C) begin
                    err_d = 1'b1;
                end else begin
                    push_en_s  = 1'b1;
                    push_val_s = (cmd_s == CMD_INTR) ? pc_q : pc_plus1_s;
                    count_d    = count_q + ONE_C;
                end
            end
            CMD_RET: begin
                if (count_q == {CW{1'b0}}) begin
                    err_d = 1'b1;
                end else begin
                    pc_d    = top_s;
                    count_d = count_q - ONE_C;
                end
            end
            CMD_LD:   pc_d = DIN;
            CMD_INC:  pc_d = pc_plus1_s;
            CMD_HOLD: pc_d = pc_q;
            default:  pc_d = pc_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == {CW{1'b0}});
    end

    // Architectural state with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= RESET_VALUE;
            count_q <= {CW{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Stack storage; contents are not cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST && push_en_s) begin
            stack_q[wr_idx_s] <= push_val_s;
        end
    end

    assign PC_COUNT    = pc_q;
    assign PC_PLUS1    = pc_plus1_s;
    assign STACK_FULL  = full_q;
    assign STACK_EMPTY = empty_q;
    assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the test plan.
module tb_pc_stack_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] DIN = 10'h000;
    logic       PC_LD = 1'b0, PC_INC = 1'b0, PC_CALL = 1'b0, PC_RET = 1'b0, PC_INTR = 1'b0;
    logic [9:0] PC_COUNT, PC_PLUS1;
    logic       STACK_FULL, STACK_EMPTY, STACK_ERR;

    pc_stack_unit #(
        .WIDTH(10), .STACK_DEPTH(8), .INTR_VECTOR(10'h3FF), .RESET_VALUE(10'h000)
    ) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN),
        .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_CALL(PC_CALL), .PC_RET(PC_RET), .PC_INTR(PC_INTR),
        .PC_COUNT(PC_COUNT), .PC_PLUS1(PC_PLUS1),
        .STACK_FULL(STACK_FULL), .STACK_EMPTY(STACK_EMPTY), .STACK_ERR(STACK_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Reference model
    logic [9:0] m_pc = 10'h000;
    logic [9:0] m_stk[$];
    logic       m_err = 1'b0;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (RST) begin
            m_pc = 10'h000;
            m_stk.delete();
            m_err = 1'b0;
        end else if (PC_INTR || PC_CALL) begin
            if (m_stk.size() == 8) m_err = 1'b1;
            else m_stk.push_back(PC_INTR ? m_pc : m_pc + 10'd1);
            m_pc = PC_INTR ? 10'h3FF : DIN;
        end else if (PC_RET) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (PC_LD) begin
            m_pc = DIN;
        end else if (PC_INC) begin
            m_pc = m_pc + 10'd1;
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_pc",    PC_COUNT, m_pc);
            chk("model_plus1", PC_PLUS1, m_pc + 10'd1);
            chk("model_full",  {9'd0, STACK_FULL},  {9'd0, m_stk.size() == 8});
            chk("model_empty", {9'd0, STACK_EMPTY}, {9'd0, m_stk.size() == 0});
            chk("model_err",   {9'd0, STACK_ERR},   {9'd0, m_err});
        end
    end

    task automatic step(input logic rst, input logic intr, input logic call, input logic ret,
                        input logic ld, input logic inc, input logic [9:0] din);
        RST = rst; PC_INTR = intr; PC_CALL = call; PC_RET = ret; PC_LD = ld; PC_INC = inc;
        DIN = din;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        RST = 1'b0; PC_INTR = 1'b0; PC_CALL = 1'b0; PC_RET = 1'b0; PC_LD = 1'b0; PC_INC = 1'b0;
    endtask

    task automatic lit_pc(input string name, input logic [9:0] exp);
        chk(name, PC_COUNT, exp);
    endtask

    task automatic lit_bit(input string name, input logic act, input logic exp);
        chk(name, {9'd0, act}, {9'd0, exp});
    endtask

    initial begin
        // Reset / increment wrap
        step(1, 0, 0, 0, 0, 0, 10'h000);
        chk_en = 1'b1;
        lit_pc("rst_pc", 10'h000);
        lit_bit("rst_empty", STACK_EMPTY, 1'b1);
        lit_bit("rst_full", STACK_FULL, 1'b0);
        lit_bit("rst_err", STACK_ERR, 1'b0);
        step(0, 0, 0, 0, 1, 0, 10'h3FE); lit_pc("ld_3fe", 10'h3FE);
        step(0, 0, 0, 0, 0, 1, 10'h000); lit_pc("inc_3ff", 10'h3FF);
        chk("plus1_wrap", PC_PLUS1, 10'h000);
        step(0, 0, 0, 0, 0, 1, 10'h000); lit_pc("inc_wrap", 10'h000);
        lit_bit("wrap_empty", STACK_EMPTY, 1'b1);
        lit_bit("wrap_err", STACK_ERR, 1'b0);
        step(0, 0, 0, 0, 0, 0, 10'h155); lit_pc("hold", 10'h000);

        // Call / return
        step(0, 0, 0, 0, 1, 0, 10'h010);
        step(0, 0, 1, 0, 0, 0, 10'h200); lit_pc("call_200", 10'h200);
        lit_bit("call_notempty", STACK_EMPTY, 1'b0);
        step(0, 0, 0, 0, 0, 1, 10'h000); lit_pc("inc_201", 10'h201);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("ret_011", 10'h011);
        lit_bit("ret_empty", STACK_EMPTY, 1'b1);

        // Interrupt then nested call
        step(0, 0, 0, 0, 1, 0, 10'h050);
        step(0, 1, 0, 0, 0, 0, 10'h000); lit_pc("intr_vec", 10'h3FF);
        step(0, 0, 1, 0, 0, 0, 10'h100); lit_pc("nest_call", 10'h100);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("nest_ret_wrap", 10'h000);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("intr_ret", 10'h050);

        // Overflow: pushes are 051, 001..007
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0, 10'(i));
        lit_bit("ovf_full", STACK_FULL, 1'b1);
        lit_bit("ovf_noerr", STACK_ERR, 1'b0);
        step(0, 0, 1, 0, 0, 0, 10'h0AA); lit_pc("ovf_pc", 10'h0AA);
        lit_bit("ovf_err", STACK_ERR, 1'b1);
        lit_bit("ovf_still_full", STACK_FULL, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1, 0, 0, 10'h000);
            lit_pc("ovf_ret", (k < 7) ? 10'(7 - k) : 10'h051);
        end
        lit_bit("ovf_drained", STACK_EMPTY, 1'b1);
        lit_bit("err_sticky", STACK_ERR, 1'b1);

        // Underflow and priority
        step(1, 0, 0, 0, 0, 0, 10'h000);
        lit_bit("rst_clears_err", STACK_ERR, 1'b0);
        step(0, 0, 0, 0, 1, 0, 10'h020);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("udf_hold", 10'h020);
        lit_bit("udf_err", STACK_ERR, 1'b1);
        lit_bit("udf_empty", STACK_EMPTY, 1'b1);
        step(0, 0, 1, 0, 1, 1, 10'h123); lit_pc("prio_call", 10'h123);
        lit_bit("prio_count1", STACK_EMPTY, 1'b0);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("prio_ret", 10'h021);
        step(0, 1, 1, 1, 1, 1, 10'h155); lit_pc("prio_intr", 10'h3FF);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("prio_intr_ret", 10'h021);
        step(0, 0, 1, 0, 0, 0, 10'h2AA);
        step(1, 1, 0, 0, 0, 0, 10'h000); lit_pc("rst_intr_pc", 10'h000);
        lit_bit("rst_intr_err", STACK_ERR, 1'b0);
        lit_bit("rst_intr_empty", STACK_EMPTY, 1'b1);
        step(0, 0, 0, 1, 0, 0, 10'h000); lit_pc("rst_discards_stack", 10'h000);
        lit_bit("post_rst_udf", STACK_ERR, 1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter with an integrated hardware return-address stack and interrupt vectoring. It sits in the fetch stage, drives the instruction-memory address, and handles sequential, jump, call, return and interrupt-entry address sequencing in one registered block. Depth, address width and interrupt vector are configurable. Stack misuse is flagged rather than silently corrupting state.

## Interface
- WIDTH, 10: address width of PC_COUNT, DIN and stack entries.
- STACK_DEPTH, 8: number of return-address entries; must be ≥ 2.
- INTR_VECTOR, {WIDTH{1'b1}}: address loaded on interrupt entry.
- RESET_VALUE, 0: PC_COUNT value after reset.
- CLK  input  1  rising-edge clock for all state.
- RST  input  1  synchronous active-high reset.
- DIN  input  WIDTH  jump/call target address.
- PC_LD  input  1  load DIN (jump).
- PC_INC  input  1  advance to next sequential address.
- PC_CALL  input  1  push return address, load DIN.
- PC_RET  input  1  pop stack top into PC.
- PC_INTR  input  1  push current PC, load INTR_VECTOR.
- PC_COUNT  output  WIDTH  registered current program address.
- PC_PLUS1  output  WIDTH  combinational PC_COUNT+1 modulo 2^WIDTH.
- STACK_FULL  output  1  registered; entry count == STACK_DEPTH.
- STACK_EMPTY  output  1  registered; entry count == 0.
- STACK_ERR  output  1  registered sticky overflow/underflow flag.

## Operation
- One command per cycle; fixed priority: RST > PC_INTR > PC_CALL > PC_RET > PC_LD > PC_INC > hold. Lower-priority requests in the same cycle are ignored, not queued.
- Hold: PC_COUNT, stack and flags unchanged.
- PC_INC: PC_COUNT <= PC_PLUS1. All-ones wraps to 0. No flag effect.
- PC_LD: PC_COUNT <= DIN. Stack untouched.
- PC_CALL: push PC_PLUS1, PC_COUNT <= DIN.
- PC_INTR: push PC_COUNT (the interrupted instruction is re-executed on return), PC_COUNT <= INTR_VECTOR.
- PC_RET: PC_COUNT <= stack top, pop.
- Stack is LIFO, entry count width $clog2(STACK_DEPTH+1), storage in flops. Only the top entry is observable, through PC_RET.
- Overflow: a push when the count == STACK_DEPTH.
  - The push is dropped. Count and contents are unchanged.
  - PC_COUNT still loads DIN or INTR_VECTOR.
  - STACK_ERR <= 1.
- Underflow: PC_RET when count == 0.
  - PC_COUNT holds.
  - Count stays 0.
  - STACK_ERR <= 1.
- STACK_ERR is sticky. Only RST clears it.
- Reset values:
  - PC_COUNT = RESET_VALUE.
  - Count = 0.
  - STACK_EMPTY = 1.
  - STACK_FULL = 0.
  - STACK_ERR = 0.
  - Stack contents are don't-care and are not cleared.

## Timing
- All state updates on the rising CLK edge. Every command takes effect in exactly 1 cycle and is visible on PC_COUNT the cycle after assertion.
- PC_PLUS1 has zero latency from PC_COUNT (combinational).
- STACK_FULL and STACK_EMPTY reflect the post-update count in the same cycle as PC_COUNT.
- A push followed by PC_RET on the next cycle returns the pushed value; no bubble is required.
- RST asserted mid-sequence (for example, depth 5) discards all stack state that edge. The next cycle shows the reset values, regardless of any other input.
- Combinational paths from inputs to outputs: none except PC_COUNT → PC_PLUS1.

## Test plan
- Reset/increment wrap: RST, then PC_LD DIN=10'h3FE, PC_INC ×2 -> PC_COUNT 3FE, 3FF, 000; STACK_EMPTY=1, STACK_ERR=0.
- Call/return: PC at 0x010, PC_CALL DIN=0x200 -> PC=0x200, count 1. PC_INC -> 0x201. PC_RET -> PC=0x011, STACK_EMPTY=1.
- Interrupt then nested call: PC=0x050.
  - PC_INTR -> PC=0x3FF.
  - PC_CALL DIN=0x100 -> PC=0x100.
  - PC_RET -> PC=0x000 (0x3FF+1 wrapped).
  - PC_RET -> PC=0x050.
- Overflow: 8 PC_CALLs (DIN=i) -> STACK_FULL=1.
  - 9th call DIN=0x0AA -> PC=0x0AA, STACK_ERR=1, count stays 8.
  - 8 PC_RETs return the 8 stored addresses in reverse order.
- Underflow and priority:
  - Empty stack, PC_RET -> PC holds, STACK_ERR=1.
  - Assert PC_CALL+PC_LD+PC_INC together DIN=0x123 -> call wins: PC=0x123, count 1.
  - RST in the same cycle as PC_INTR -> PC=RESET_VALUE, STACK_ERR=0.
